// File: rtl/pll_lock_sequencer.sv
// Sequences the iCE40 PLL through reset hold, lock wait and lock qualification,
// re-sequencing on lock loss and latching a fault after repeated timeouts.
module pll_lock_sequencer #(
    parameter int HOLD_CYCLES   = 12,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 120,
    parameter int MAX_RETRY     = 3,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   REFERENCECLK,
    input  logic                   RESET,
    input  logic                   pll_lock,
    input  logic                   req_restart,
    output logic                   pll_resetb,
    output logic                   pll_ready,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] relock_count,
    output logic [2:0]             state_dbg
);

    localparam int MAX_HW   = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC  = (MAX_HW > STABLE_CYCLES) ? MAX_HW : STABLE_CYCLES;
    localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [COUNT_WIDTH-1:0] relock_q, relock_d;
    logic                   sync1_q, sync2_q;
    logic                   pll_resetb_q, pll_resetb_d;
    logic                   pll_ready_q, pll_ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_s;

    assign lock_s = sync2_q;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;

        if (req_restart) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAULT;
                        end else begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ST_HOLD;
                        end
                    end
                end
                // Lock chatter during qualification is not counted as a retry.
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_HOLD;
                        if (relock_q != '1) relock_d = relock_q + COUNT_WIDTH'(1);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end

        if (req_restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == ST_HOLD) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // Outputs are registered from the next state so they change on the transition edge.
        pll_resetb_d = !((state_d == ST_HOLD) || (state_d == ST_FAULT));
        pll_ready_d  = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            relock_q     <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            pll_resetb_q <= 1'b0;
            pll_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            relock_q     <= relock_d;
            sync1_q      <= pll_lock;
            sync2_q      <= sync1_q;
            pll_resetb_q <= pll_resetb_d;
            pll_ready_q  <= pll_ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb   = pll_resetb_q;
    assign pll_ready    = pll_ready_q;
    assign fault        = fault_q;
    assign relock_count = relock_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: directed lock scenarios with hand-computed
// latencies, then randomized lock/restart/reset traffic against a phase-level model.
module tb_pll_lock_sequencer;

    localparam int HOLD    = 4;
    localparam int TIMEOUT = 16;
    localparam int STABLE  = 8;
    localparam int RETRIES = 2;
    localparam int CW      = 2;
    localparam int RELOCK_MAX = (1 << CW) - 1;

    localparam int P_HOLD   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic          REFERENCECLK = 1'b0;
    logic          RESET        = 1'b1;
    logic          pll_lock     = 1'b0;
    logic          req_restart  = 1'b0;
    logic          pll_resetb;
    logic          pll_ready;
    logic          fault;
    logic [CW-1:0] relock_count;
    logic [2:0]    state_dbg;

    int nChecks = 0;
    int nFails  = 0;
    bit checkOn = 0;

    // Phase-level model: which phase we are in, how many edges spent there,
    // consecutive timeouts, lock losses in RUN, and the two-edge lock delay.
    int mPhase  = P_HOLD;
    int mAge    = 0;
    int mRetry  = 0;
    int mRelock = 0;
    int lockPipe[2] = '{0, 0};

    pll_lock_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .LOCK_TIMEOUT  (TIMEOUT),
        .STABLE_CYCLES (STABLE),
        .MAX_RETRY     (RETRIES),
        .COUNT_WIDTH   (CW)
    ) dut (
        .REFERENCECLK (REFERENCECLK),
        .RESET        (RESET),
        .pll_lock     (pll_lock),
        .req_restart  (req_restart),
        .pll_resetb   (pll_resetb),
        .pll_ready    (pll_ready),
        .fault        (fault),
        .relock_count (relock_count),
        .state_dbg    (state_dbg)
    );

    always #5 REFERENCECLK = ~REFERENCECLK;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic enterPhase(input int p);
        mPhase = p;
        mAge   = 0;
    endtask

    task automatic modelReset();
        enterPhase(P_HOLD);
        mRetry      = 0;
        mRelock     = 0;
        lockPipe[0] = 0;
        lockPipe[1] = 0;
    endtask

    task automatic modelStep(input int rr, input int pl);
        int ls;
        ls          = lockPipe[1];
        lockPipe[1] = lockPipe[0];
        lockPipe[0] = pl;
        if (rr != 0) begin
            enterPhase(P_HOLD);
            mRetry = 0;
            return;
        end
        mAge++;
        case (mPhase)
            P_HOLD:   if (mAge == HOLD) enterPhase(P_WAIT);
            P_WAIT: begin
                if (ls != 0) enterPhase(P_STABLE);
                else if (mAge == TIMEOUT) begin
                    if (mRetry + 1 == RETRIES) enterPhase(P_FAULT);
                    else begin
                        mRetry++;
                        enterPhase(P_HOLD);
                    end
                end
            end
            P_STABLE: begin
                if (ls == 0) enterPhase(P_WAIT);
                else if (mAge == STABLE) begin
                    mRetry = 0;
                    enterPhase(P_RUN);
                end
            end
            P_RUN: begin
                if (ls == 0) begin
                    if (mRelock < RELOCK_MAX) mRelock++;
                    enterPhase(P_HOLD);
                end
            end
            default: ;
        endcase
    endtask

    initial begin : modelProc
        forever begin
            @(posedge REFERENCECLK or negedge RESET);
            if (!RESET) modelReset();
            else modelStep(int'(req_restart), int'(pll_lock));
        end
    end

    // Every cycle, outputs must match what the model's phase implies.
    always @(negedge REFERENCECLK) begin
        if (checkOn) begin
            checkOutput("model state_dbg", int'(state_dbg), mPhase);
            checkOutput("model pll_resetb", int'(pll_resetb), (mPhase == P_HOLD || mPhase == P_FAULT) ? 0 : 1);
            checkOutput("model pll_ready", int'(pll_ready), (mPhase == P_RUN) ? 1 : 0);
            checkOutput("model fault", int'(fault), (mPhase == P_FAULT) ? 1 : 0);
            checkOutput("model relock_count", int'(relock_count), mRelock);
        end
    end

    task automatic applyStimulus(input bit lock, input bit rr);
        @(negedge REFERENCECLK);
        #1;
        pll_lock    = lock;
        req_restart = rr;
    endtask

    // Counts rising edges until the chosen output reaches val; n = -1 on timeout.
    task automatic countEdgesUntil(input int sel, input bit val, input int limit, output int n);
        bit hit;
        hit = 0;
        n   = 0;
        while (!hit && n < limit) begin
            @(posedge REFERENCECLK);
            #1;
            n++;
            case (sel)
                0:       hit = (pll_resetb == val);
                1:       hit = (pll_ready == val);
                default: hit = (fault == val);
            endcase
        end
        if (!hit) n = -1;
    endtask

    task automatic waitModel(input int phase, input int age, input string name);
        int n;
        n = 0;
        while (!(mPhase == phase && mAge == age) && n < 200) begin
            @(posedge REFERENCECLK);
            #1;
            n++;
        end
        checkOutput(name, (mPhase == phase && mAge == age) ? 1 : 0, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " pll_resetb"}, int'(pll_resetb), 0);
        checkOutput({tag, " pll_ready"}, int'(pll_ready), 0);
        checkOutput({tag, " fault"}, int'(fault), 0);
        checkOutput({tag, " relock_count"}, int'(relock_count), 0);
        checkOutput({tag, " state_dbg"}, int'(state_dbg), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        int holdLeft;
        bit lockLvl;
        bit rr;
        int expRelock[5] = '{1, 2, 3, 3, 3};

        #2 RESET = 1'b0;
        checkOn = 1;
        #1 checkResetValues("reset");
        applyStimulus(0, 0);
        applyStimulus(0, 0);

        // Scenario 1: first power-up lock.
        @(negedge REFERENCECLK);
        #1 RESET = 1'b1;
        countEdgesUntil(0, 1, 50, n);
        checkOutput("first hold length", n, HOLD);
        repeat (5) applyStimulus(1'b0, 1'b0);
        applyStimulus(1, 0);
        @(posedge REFERENCECLK);
        #1;
        countEdgesUntil(1, 1, 100, n);
        checkOutput("first ready latency", n, STABLE + 2);
        checkOutput("first run state_dbg", int'(state_dbg), 3);

        // Scenario 2: lock lost, never returns, retries exhaust into FAULT.
        applyStimulus(0, 0);
        countEdgesUntil(1, 0, 20, n);
        checkOutput("ready fall latency", n, 3);
        checkOutput("relock after first loss", int'(relock_count), 1);
        countEdgesUntil(2, 1, 200, n);
        checkOutput("edges to fault", n, 2 * (HOLD + TIMEOUT));
        checkOutput("fault state_dbg", int'(state_dbg), 4);
        checkOutput("fault pll_resetb", int'(pll_resetb), 0);
        repeat (6) applyStimulus(1, 0);
        checkOutput("fault ignores lock", int'(fault), 1);
        applyStimulus(1, 1);
        applyStimulus(1, 0);
        checkOutput("restart clears fault", int'(fault), 0);
        checkOutput("restart state_dbg", int'(state_dbg), 0);
        checkOutput("restart pll_resetb", int'(pll_resetb), 0);
        countEdgesUntil(0, 1, 50, n);
        checkOutput("restart hold length", n, HOLD);

        // Scenario 3: one-cycle lock dropout seen at qualification count 5.
        waitModel(P_STABLE, 3, "reach stable");
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        @(posedge REFERENCECLK);
        #1;
        countEdgesUntil(1, 1, 100, n);
        checkOutput("ready after chatter", n, STABLE + 2);

        // Scenario 6: restart on the edge RUN would see the lock loss.
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        checkOutput("restart in run state_dbg", int'(state_dbg), 0);
        checkOutput("restart in run relock", int'(relock_count), 1);
        checkOutput("restart in run ready", int'(pll_ready), 0);
        countEdgesUntil(2, 1, 200, n);
        checkOutput("full retries after restart", n, 2 * (HOLD + TIMEOUT));

        // Scenario 5: reset during FAULT, then during STABLE, lock held high.
        #2 RESET = 1'b0;
        pll_lock = 1'b1;
        #1 checkResetValues("reset in fault");
        applyStimulus(1, 0);
        @(negedge REFERENCECLK);
        #1 RESET = 1'b1;
        countEdgesUntil(0, 1, 50, n);
        checkOutput("hold after fault reset", n, HOLD);
        waitModel(P_STABLE, 2, "reach stable again");
        #2 RESET = 1'b0;
        #1 checkResetValues("reset in stable");
        applyStimulus(1, 0);
        @(negedge REFERENCECLK);
        #1 RESET = 1'b1;
        countEdgesUntil(0, 1, 50, n);
        checkOutput("hold after stable reset", n, HOLD);
        countEdgesUntil(1, 1, 100, n);
        checkOutput("ready after stable reset", (n > 0) ? 1 : 0, 1);

        // Scenario 4: repeated lock losses saturate relock_count.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0);
            countEdgesUntil(1, 0, 20, n);
            checkOutput("ready fall on relock", n, 3);
            checkOutput("relock_count sequence", int'(relock_count), expRelock[i]);
            applyStimulus(1, 0);
            countEdgesUntil(1, 1, 100, n);
            checkOutput("relock reaches run", (n > 0) ? 1 : 0, 1);
        end

        // Randomized traffic against the model.
        holdLeft = 0;
        lockLvl  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (holdLeft == 0) begin
                lockLvl  = ($urandom_range(0, 3) != 0);
                holdLeft = $urandom_range(1, 40);
            end
            holdLeft--;
            rr = ($urandom_range(0, 63) == 0);
            applyStimulus(lockLvl, rr);
            if ($urandom_range(0, 499) == 0) begin
                #1 RESET = 1'b0;
                @(negedge REFERENCECLK);
                #1 RESET = 1'b1;
            end
        end

        applyStimulus(0, 0);
        checkOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
